coin_acceptor: RTL and testbench

COIN_ACCEPTOR -- requirements
Module: coin_acceptor

---
 rtl/vm_pkg.sv | 13 +
 rtl/coin_acceptor_if.sv | 23 ++
 rtl/coin_debounce.sv | 51 +++++
 rtl/coin_acceptor.sv | 107 ++++++++++
 tb/tb_coin_acceptor.sv | 306 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/vm_pkg.sv
// Shared vending-machine definitions: coin-type encoding and the default
// tuning constants for the coin acceptor, reused by the vending FSM bench.
package vm_pkg;

  typedef enum logic {
    COIN_ONE = 1'b0,
    COIN_TWO = 1'b1
  } coin_t;

  localparam int DEBOUNCE_CYCLES_DEF = 4;
  localparam int FIFO_DEPTH_DEF      = 4;

endpackage

// File: rtl/coin_acceptor_if.sv
// Signal bundle between a coin-sensor/vending side (master) and the coin
// acceptor (slave).
interface coin_acceptor_if;

  logic       coin_one_raw;
  logic       coin_two_raw;
  logic       hold;
  logic       rupee_one;
  logic       rupee_two;
  logic       coin_reject;
  logic [3:0] queue_count;

  modport master (
    output coin_one_raw, coin_two_raw, hold,
    input  rupee_one, rupee_two, coin_reject, queue_count
  );

  modport slave (
    input  coin_one_raw, coin_two_raw, hold,
    output rupee_one, rupee_two, coin_reject, queue_count
  );

endinterface

// File: rtl/coin_debounce.sv
// One coin-slot channel: two-flop synchroniser, stability counter, debounced
// level and a single-cycle strobe on the level's 0->1 transition.
module coin_debounce
  import vm_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
  input  logic clk,
  input  logic reset_n,
  input  logic i_raw,
  output logic o_rise
);

  logic       r_sync1;
  logic       r_sync2;
  logic       r_level;
  logic [3:0] r_cnt;
  logic       w_settled;

  // The synchronised value has disagreed long enough: the level flips this edge.
  assign w_settled = (r_sync2 != r_level) && (r_cnt == 4'(DEBOUNCE_CYCLES - 1));
  assign o_rise    = w_settled && r_sync2;

  // Two-flop synchroniser for the asynchronous sensor.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
    end else begin
      r_sync1 <= i_raw;
      r_sync2 <= r_sync1;
    end
  end

  // Count consecutive disagreeing samples; any agreeing sample restarts the count.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt   <= '0;
      r_level <= 1'b0;
    end else if (r_sync2 == r_level) begin
      r_cnt <= '0;
    end else if (w_settled) begin
      r_cnt   <= '0;
      r_level <= r_sync2;
    end else begin
      r_cnt <= r_cnt + 4'd1;
    end
  end

endmodule

// File: rtl/coin_acceptor.sv
// Coin acceptor: debounces the two slot sensors, turns rising edges into coin
// events, queues them in order and hands them to the vending FSM one per
// cycle as registered credit pulses, rejecting simultaneous or overflowing coins.
module coin_acceptor
  import vm_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int FIFO_DEPTH      = FIFO_DEPTH_DEF
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       coin_one_raw,
  input  logic       coin_two_raw,
  input  logic       hold,
  output logic       rupee_one,
  output logic       rupee_two,
  output logic       coin_reject,
  output logic [3:0] queue_count
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);

  logic             w_rise_one;
  logic             w_rise_two;
  logic             w_single;
  logic             w_full;
  logic             w_pop;
  logic             w_push;
  logic             w_reject;
  coin_t            w_push_type;
  coin_t            w_pop_type;

  coin_t            r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [3:0]       r_count;
  logic             r_rupee_one;
  logic             r_rupee_two;
  logic             r_reject;

  coin_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_one (
    .clk     (clk),
    .reset_n (reset_n),
    .i_raw   (coin_one_raw),
    .o_rise  (w_rise_one)
  );

  coin_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_two (
    .clk     (clk),
    .reset_n (reset_n),
    .i_raw   (coin_two_raw),
    .o_rise  (w_rise_two)
  );

  // Event classification and FIFO push/pop decisions for this edge.
  // NOTE: every combinational output is assigned on every path, so no latch can be inferred.
  always_comb begin
    w_single    = w_rise_one ^ w_rise_two;
    w_push_type = w_rise_two ? COIN_TWO : COIN_ONE;
    w_full      = (r_count == 4'(FIFO_DEPTH));
    w_pop       = (r_count != 4'd0) && !hold;
    // A full FIFO still accepts when the head leaves on the same edge.
    w_push      = w_single && (!w_full || w_pop);
    w_reject    = (w_rise_one && w_rise_two) || (w_single && !w_push);
    w_pop_type  = r_mem[r_rd_ptr];
  end

  // Coin storage.
  // NOTE: the array is deliberately not reset; r_count gates every read, so stale entries are never seen.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= w_push_type;
    end
  end

  // Pointers wrap modulo FIFO_DEPTH; occupancy comes from the count.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      r_count <= r_count + 4'(w_push) - 4'(w_pop);
    end
  end

  // Registered one-cycle credit and reject pulses.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rupee_one <= 1'b0;
      r_rupee_two <= 1'b0;
      r_reject    <= 1'b0;
    end else begin
      r_rupee_one <= w_pop && (w_pop_type == COIN_ONE);
      r_rupee_two <= w_pop && (w_pop_type == COIN_TWO);
      r_reject    <= w_reject;
    end
  end

  assign rupee_one   = r_rupee_one;
  assign rupee_two   = r_rupee_two;
  assign coin_reject = r_reject;
  assign queue_count = r_count;

endmodule

// File: tb/tb_coin_acceptor.sv
// Bench for coin_acceptor: a queue-based reference model predicts every credit
// and reject with its cycle; a monitor compares them as the DUT presents them.
`timescale 1ns/1ps
module tb_coin_acceptor;
  import vm_pkg::*;

  localparam int DEB   = DEBOUNCE_CYCLES_DEF;
  localparam int DEPTH = FIFO_DEPTH_DEF;

  typedef struct {
    coin_t kind;
    int    cyc;
  } credit_t;

  logic clk     = 1'b0;
  logic reset_n = 1'b0;

  coin_acceptor_if bus ();

  always #5 clk = ~clk;

  coin_acceptor #(.DEBOUNCE_CYCLES(DEB), .FIFO_DEPTH(DEPTH)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .coin_one_raw (bus.coin_one_raw),
    .coin_two_raw (bus.coin_two_raw),
    .hold         (bus.hold),
    .rupee_one    (bus.rupee_one),
    .rupee_two    (bus.rupee_two),
    .coin_reject  (bus.coin_reject),
    .queue_count  (bus.queue_count)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  int      cyc = 0;
  logic    m_prev1 [2];
  logic    m_prev2 [2];
  logic    m_lvl   [2];
  int      m_run   [2];
  coin_t   m_fifo [$];
  credit_t exp_credit_q [$];
  int      exp_rej_q [$];

  always @(posedge clk or negedge reset_n) begin : model
    logic    raw  [2];
    logic    rise [2];
    logic    synced;
    coin_t   head;
    credit_t e;
    if (!reset_n) begin
      for (int c = 0; c < 2; c++) begin
        m_prev1[c] = 1'b0;
        m_prev2[c] = 1'b0;
        m_lvl[c]   = 1'b0;
        m_run[c]   = 0;
      end
      m_fifo.delete();
      exp_credit_q.delete();
      exp_rej_q.delete();
    end else begin
      cyc++;
      raw[0] = bus.coin_one_raw;
      raw[1] = bus.coin_two_raw;
      for (int c = 0; c < 2; c++) begin
        // the debouncer sees the raw value from two edges earlier
        synced     = m_prev2[c];
        m_prev2[c] = m_prev1[c];
        m_prev1[c] = raw[c];
        rise[c]    = 1'b0;
        if (synced != m_lvl[c]) begin
          m_run[c]++;
          if (m_run[c] == DEB) begin
            m_lvl[c] = synced;
            m_run[c] = 0;
            rise[c]  = synced;
          end
        end else begin
          m_run[c] = 0;
        end
      end
      if (m_fifo.size() > 0 && !bus.hold) begin
        head   = m_fifo.pop_front();
        e.kind = head;
        e.cyc  = cyc;
        exp_credit_q.push_back(e);
      end
      if (rise[0] && rise[1]) begin
        exp_rej_q.push_back(cyc);
      end else if (rise[0] || rise[1]) begin
        if (m_fifo.size() < DEPTH) m_fifo.push_back(rise[1] ? COIN_TWO : COIN_ONE);
        else                       exp_rej_q.push_back(cyc);
      end
    end
  end

  // ---------------- monitor ----------------
  int      n_one = 0;
  int      n_two = 0;
  int      n_rej = 0;
  credit_t obs_q [$];

  always @(negedge clk) begin : monitor
    credit_t got;
    check("rupee_exclusive", bus.rupee_one & bus.rupee_two, 1'b0);
    while (exp_credit_q.size() > 0 && exp_credit_q[0].cyc < cyc) begin
      check("credit_missing_cycle", cyc, exp_credit_q[0].cyc);
      void'(exp_credit_q.pop_front());
    end
    while (exp_rej_q.size() > 0 && exp_rej_q[0] < cyc) begin
      check("reject_missing_cycle", cyc, exp_rej_q[0]);
      void'(exp_rej_q.pop_front());
    end
    if (bus.rupee_one || bus.rupee_two) begin
      got.kind = bus.rupee_two ? COIN_TWO : COIN_ONE;
      got.cyc  = cyc;
      obs_q.push_back(got);
      if (got.kind == COIN_ONE) n_one++;
      else                      n_two++;
      if (exp_credit_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL credit_unexpected: pulse type %0d at cycle %0d, none predicted", got.kind, cyc);
      end else begin
        check("credit_cycle", cyc, exp_credit_q[0].cyc);
        check("credit_type", got.kind, exp_credit_q[0].kind);
        void'(exp_credit_q.pop_front());
      end
    end
    if (bus.coin_reject) begin
      n_rej++;
      if (exp_rej_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL reject_unexpected: pulse at cycle %0d, none predicted", cyc);
      end else begin
        check("reject_cycle", cyc, exp_rej_q[0]);
        void'(exp_rej_q.pop_front());
      end
    end
    check("queue_count", bus.queue_count, m_fifo.size());
  end

  // ---------------- stimulus ----------------
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic drive(input logic one, input logic two, input int n);
    bus.coin_one_raw = one;
    bus.coin_two_raw = two;
    tick(n);
  endtask

  task automatic insert(input coin_t kind);
    drive(kind == COIN_ONE, kind == COIN_TWO, 8);
    drive(1'b0, 1'b0, 8);
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_rupee_one"}, bus.rupee_one, 1'b0);
    check({tag, "_rupee_two"}, bus.rupee_two, 1'b0);
    check({tag, "_reject"}, bus.coin_reject, 1'b0);
    check({tag, "_count"}, bus.queue_count, 0);
  endtask

  int base_one, base_two, base_rej, start;
  coin_t seq5 [5];

  initial begin
    bus.coin_one_raw = 1'b0;
    bus.coin_two_raw = 1'b0;
    bus.hold         = 1'b0;
    reset_n          = 1'b0;
    tick(3);
    check_outputs_zero("reset");
    reset_n = 1'b1;
    tick(2);

    // clean one-rupee insertion, latency from first sampling edge
    obs_q.delete();
    base_rej = n_rej;
    start    = cyc;
    drive(1'b1, 1'b0, 10);
    drive(1'b0, 1'b0, 20);
    check("clean_pulses", obs_q.size(), 1);
    if (obs_q.size() == 1) begin
      check("clean_type", obs_q[0].kind, COIN_ONE);
      check("clean_latency", obs_q[0].cyc, start + DEB + 3);
    end
    check("clean_rejects", n_rej - base_rej, 0);
    check("clean_count", bus.queue_count, 0);

    // bouncing two-rupee sensor
    base_one = n_one; base_two = n_two; base_rej = n_rej;
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b1, 1);
      drive(1'b0, 1'b0, 1);
    end
    drive(1'b0, 1'b1, 8);
    drive(1'b0, 1'b0, 20);
    check("bounce_two", n_two - base_two, 1);
    check("bounce_one", n_one - base_one, 0);
    check("bounce_rej", n_rej - base_rej, 0);

    // simultaneous insertion
    obs_q.delete();
    base_rej = n_rej;
    drive(1'b1, 1'b1, 10);
    drive(1'b0, 1'b0, 20);
    check("both_rej", n_rej - base_rej, 1);
    check("both_pulses", obs_q.size(), 0);
    check("both_count", bus.queue_count, 0);

    // hold backpressure, then three consecutive credits
    bus.hold = 1'b1;
    insert(COIN_ONE);
    insert(COIN_TWO);
    insert(COIN_ONE);
    check("hold_count", bus.queue_count, 3);
    obs_q.delete();
    start    = cyc;
    bus.hold = 1'b0;
    tick(10);
    check("hold_pulses", obs_q.size(), 3);
    if (obs_q.size() == 3) begin
      check("hold_first_cycle", obs_q[0].cyc, start + 1);
      check("hold_t0", obs_q[0].kind, COIN_ONE);
      check("hold_t1", obs_q[1].kind, COIN_TWO);
      check("hold_t2", obs_q[2].kind, COIN_ONE);
      check("hold_c1", obs_q[1].cyc, obs_q[0].cyc + 1);
      check("hold_c2", obs_q[2].cyc, obs_q[0].cyc + 2);
    end

    // overflow: fifth coin rejected, first four kept in order
    seq5[0] = COIN_ONE; seq5[1] = COIN_TWO; seq5[2] = COIN_TWO;
    seq5[3] = COIN_ONE; seq5[4] = COIN_TWO;
    base_rej = n_rej;
    bus.hold = 1'b1;
    for (int i = 0; i < 5; i++) insert(seq5[i]);
    check("ovf_count", bus.queue_count, DEPTH);
    check("ovf_rej", n_rej - base_rej, 1);
    obs_q.delete();
    bus.hold = 1'b0;
    tick(10);
    check("ovf_pulses", obs_q.size(), DEPTH);
    for (int i = 0; i < DEPTH && i < obs_q.size(); i++) check("ovf_order", obs_q[i].kind, seq5[i]);

    // reset with two coins queued
    bus.hold = 1'b1;
    insert(COIN_ONE);
    insert(COIN_TWO);
    check("rst_pre_count", bus.queue_count, 2);
    obs_q.delete();
    base_rej = n_rej;
    reset_n  = 1'b0;
    #1;
    check_outputs_zero("rst_now");
    tick(3);
    reset_n  = 1'b1;
    bus.hold = 1'b0;
    drive(1'b0, 1'b0, 20);
    check("rst_after_pulses", obs_q.size(), 0);
    check("rst_after_rej", n_rej - base_rej, 0);

    // sensor already high when reset releases counts as a fresh coin
    reset_n = 1'b0;
    bus.coin_one_raw = 1'b1;
    tick(3);
    obs_q.delete();
    reset_n = 1'b1;
    tick(10);
    drive(1'b0, 1'b0, 20);
    check("rel_high_pulses", obs_q.size(), 1);
    if (obs_q.size() == 1) check("rel_high_type", obs_q[0].kind, COIN_ONE);

    // randomized sensor activity and backpressure
    for (int seg = 0; seg < 120; seg++) begin
      bus.hold = ($urandom_range(0, 3) == 0);
      drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom_range(1, 12));
    end
    bus.hold = 1'b0;
    drive(1'b0, 1'b0, 40);

    check("drain_credits", exp_credit_q.size(), 0);
    check("drain_rejects", exp_rej_q.size(), 0);
    check("drain_count", bus.queue_count, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
